// File: rtl/arbitro_multiplexador_pkg.sv
// Shared definitions for the round-robin arbiter that drives the 4:1
// datapath multiplexer select.
package arbitro_multiplexador_pkg;

   localparam int unsigned N_REQ            = 4;
   localparam int unsigned MAX_POSSE_PADRAO = 8;

   typedef enum logic [1:0] {
      OCIOSO    = 2'd0,
      CONCEDIDO = 2'd1,
      LIBERA    = 2'd2
   } estado_t;

endpackage

// File: rtl/arbitro_multiplexador_seletor_rr.sv
// Combinational round-robin search: first set request bit starting just
// after the last granted index, wrapping around.
module seletor_rr
   import arbitro_multiplexador_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic [1:0]       i_ultimo,
   output logic [1:0]       o_vencedor,
   output logic             o_algum
);

   // Scan the four positions in priority order; the first hit wins.
   always_comb begin
      o_vencedor = '0;
      o_algum    = 1'b0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         logic [1:0] w_idx;
         w_idx = 2'((32'(i_ultimo) + k) % N_REQ);
         if (!o_algum && i_req[w_idx]) begin
            o_vencedor = w_idx;
            o_algum    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arbitro_multiplexador.sv
// Round-robin arbiter with bounded ownership for a shared 16-bit datapath
// multiplexer. A one-cycle LIBERA gap separates every ownership change so
// the registered multiplexer never shows two owners back to back.
module arbitro_multiplexador
   import arbitro_multiplexador_pkg::*;
#(
   parameter int unsigned MAX_POSSE = MAX_POSSE_PADRAO
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] set,
   output logic       valido,
   output logic [1:0] fonte
);

   estado_t    r_estado;
   estado_t    w_estado_prox;
   logic [3:0] r_gnt;
   logic [3:0] w_gnt_prox;
   logic [1:0] r_set;
   logic [1:0] w_set_prox;
   logic [3:0] r_contador;
   logic [3:0] w_contador_prox;
   logic [1:0] r_ultimo;
   logic [1:0] w_ultimo_prox;
   logic       r_valido;
   logic [1:0] r_fonte;

   logic [1:0] w_vencedor;
   logic       w_algum;
   logic       w_fim_posse;

   seletor_rr u_seletor_rr (
      .i_req      (req),
      .i_ultimo   (r_ultimo),
      .o_vencedor (w_vencedor),
      .o_algum    (w_algum)
   );

   assign w_fim_posse = !req[r_set] || (r_contador == 4'(MAX_POSSE - 1));

   // Next-state, next-grant and counter logic.
   always_comb begin
      w_estado_prox   = r_estado;
      w_gnt_prox      = r_gnt;
      w_set_prox      = r_set;
      w_contador_prox = r_contador;
      w_ultimo_prox   = r_ultimo;
      unique case (r_estado)
         OCIOSO, LIBERA: begin
            w_gnt_prox = '0;
            if (w_algum) begin
               w_estado_prox          = CONCEDIDO;
               w_gnt_prox[w_vencedor] = 1'b1;
               w_set_prox             = w_vencedor;
               w_contador_prox        = '0;
               w_ultimo_prox          = w_vencedor;
            end else begin
               w_estado_prox = OCIOSO;
            end
         end
         CONCEDIDO: begin
            if (w_fim_posse) begin
               w_estado_prox = LIBERA;
               w_gnt_prox    = '0;
            end else begin
               w_contador_prox = r_contador + 4'd1;
            end
         end
         default: begin
            w_estado_prox = OCIOSO;
            w_gnt_prox    = '0;
         end
      endcase
   end

   // State and grant registers; valido/fonte track the mux register latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_estado   <= OCIOSO;
         r_gnt      <= '0;
         r_set      <= '0;
         r_contador <= '0;
         r_ultimo   <= 2'd3;
         r_valido   <= 1'b0;
         r_fonte    <= '0;
      end else begin
         r_estado   <= w_estado_prox;
         r_gnt      <= w_gnt_prox;
         r_set      <= w_set_prox;
         r_contador <= w_contador_prox;
         r_ultimo   <= w_ultimo_prox;
         r_valido   <= (r_estado == CONCEDIDO);
         r_fonte    <= r_set;
      end
   end

   assign gnt    = r_gnt;
   assign set    = r_set;
   assign valido = r_valido;
   assign fonte  = r_fonte;

endmodule

// File: tb/tb_arbitro_multiplexador.sv
// Self-checking bench: directed vector table, periodic grant patterns and
// randomized traffic checked against a behavioural ownership model.
module tb_arbitro_multiplexador;

   logic       clk;
   logic       rst;
   logic [3:0] req;

   logic [3:0] g8, g2;
   logic [1:0] s8, s2, f8, f2;
   logic       v8, v2;

   int unsigned n_testes = 0;
   int unsigned n_falhas = 0;

   // Model state per instance: 0 -> MAX_POSSE=8, 1 -> MAX_POSSE=2
   int         m_dono  [2];
   int         m_tempo [2];
   int         m_ultimo[2];
   logic [1:0] m_set   [2];
   logic       m_val   [2];
   logic [1:0] m_fonte [2];
   int         m_max   [2];

   logic       armado = 1'b0;
   logic       v8_ant, v2_ant;
   logic [1:0] f8_ant, f2_ant;

   arbitro_multiplexador #(.MAX_POSSE(8)) dut8 (
      .clk(clk), .rst(rst), .req(req),
      .gnt(g8), .set(s8), .valido(v8), .fonte(f8)
   );

   arbitro_multiplexador #(.MAX_POSSE(2)) dut2 (
      .clk(clk), .rst(rst), .req(req),
      .gnt(g2), .set(s2), .valido(v2), .fonte(f2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      n_testes++;
      if (atual !== esperado) begin
         n_falhas++;
         $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
      end
   endtask

   // Ownership model: a requester owns the bus for up to m_max cycles,
   // then a free cycle follows before the next owner is picked.
   task automatic modelo(input int i, input logic [3:0] r, input logic rs);
      if (rs) begin
         m_dono[i]   = -1;
         m_tempo[i]  = 0;
         m_ultimo[i] = 3;
         m_set[i]    = 2'd0;
         m_val[i]    = 1'b0;
         m_fonte[i]  = 2'd0;
      end else begin
         m_val[i]   = (m_dono[i] >= 0);
         m_fonte[i] = m_set[i];
         if (m_dono[i] >= 0) begin
            if (!r[m_dono[i]] || m_tempo[i] == m_max[i]) m_dono[i] = -1;
            else m_tempo[i]++;
         end else begin
            for (int k = 1; k <= 4; k++) begin
               int c;
               c = (m_ultimo[i] + k) % 4;
               if (r[c]) begin
                  m_dono[i]   = c;
                  m_tempo[i]  = 1;
                  m_ultimo[i] = c;
                  m_set[i]    = 2'(c);
                  break;
               end
            end
         end
      end
   endtask

   function automatic logic [3:0] gnt_modelo(input int i);
      return (m_dono[i] >= 0) ? (4'b0001 << m_dono[i]) : 4'b0000;
   endfunction

   task automatic verifica_modelo();
      cmp("m8.gnt",    32'(g8), 32'(gnt_modelo(0)));
      cmp("m8.set",    32'(s8), 32'(m_set[0]));
      cmp("m8.valido", 32'(v8), 32'(m_val[0]));
      if (m_val[0]) cmp("m8.fonte", 32'(f8), 32'(m_fonte[0]));
      cmp("m2.gnt",    32'(g2), 32'(gnt_modelo(1)));
      cmp("m2.set",    32'(s2), 32'(m_set[1]));
      cmp("m2.valido", 32'(v2), 32'(m_val[1]));
      if (m_val[1]) cmp("m2.fonte", 32'(f2), 32'(m_fonte[1]));
   endtask

   task automatic ciclo(input logic [3:0] r, input logic rs);
      req = r;
      rst = rs;
      @(posedge clk);
      modelo(0, r, rs);
      modelo(1, r, rs);
      #1;
      verifica_modelo();
   endtask

   // Structural properties checked on the falling edge.
   always @(negedge clk) begin
      if (armado) begin
         cmp("onehot8", 32'($onehot0(g8)), 32'd1);
         cmp("onehot2", 32'($onehot0(g2)), 32'd1);
         if (v8_ant && v8) cmp("troca8", 32'(f8), 32'(f8_ant));
         if (v2_ant && v2) cmp("troca2", 32'(f2), 32'(f2_ant));
      end
      v8_ant = v8; f8_ant = f8;
      v2_ant = v2; f2_ant = f2;
   end

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] set;
      logic       valido;
      logic [1:0] fonte;
   } vetor_t;

   vetor_t tab[21];

   initial begin
      logic [3:0] r_alea;
      logic [3:0] esperado;
      m_max[0] = 8;
      m_max[1] = 2;
      req = 4'b0000;
      rst = 1'b1;

      // Directed vectors for the MAX_POSSE=8 instance
      tab[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0};
      tab[1]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, 2'd0};
      tab[2]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 2'd2};
      tab[3]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 2'd2};
      tab[4]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b1, 2'd2};
      tab[5]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 2'd2};
      tab[6]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 2'd2};
      tab[7]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, 2'd2};
      tab[8]  = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 2'd1};
      tab[9]  = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 2'd1};
      tab[10] = '{1'b0, 4'b1000, 4'b0000, 2'd1, 1'b1, 2'd1};
      tab[11] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b0, 2'd1};
      tab[12] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 2'd3};
      tab[13] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 2'd3};
      tab[14] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 2'd3};
      tab[15] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 2'd3};
      tab[16] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 2'd3};
      tab[17] = '{1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0, 2'd0};
      tab[18] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b0, 2'd0};
      tab[19] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b1, 2'd3};
      tab[20] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 2'd3};

      for (int i = 0; i < 21; i++) begin
         ciclo(tab[i].req, tab[i].rst);
         if (i == 0) armado = 1'b1;
         cmp($sformatf("vet%0d.gnt", i),    32'(g8), 32'(tab[i].gnt));
         cmp($sformatf("vet%0d.set", i),    32'(s8), 32'(tab[i].set));
         cmp($sformatf("vet%0d.valido", i), 32'(v8), 32'(tab[i].valido));
         cmp($sformatf("vet%0d.fonte", i),  32'(f8), 32'(tab[i].fonte));
      end

      // All four requesting: 8-cycle grants in order 0,1,2,3,0 with one gap
      ciclo(4'b0000, 1'b1);
      for (int k = 1; k <= 45; k++) begin
         ciclo(4'b1111, 1'b0);
         esperado = (((k - 1) % 9) < 8) ? (4'b0001 << (((k - 1) / 9) % 4)) : 4'b0000;
         cmp($sformatf("rr8.c%0d", k), 32'(g8), 32'(esperado));
      end

      // Single requester with MAX_POSSE=2: 2 granted, 1 gap, repeat
      ciclo(4'b0000, 1'b1);
      for (int k = 1; k <= 12; k++) begin
         ciclo(4'b0001, 1'b0);
         esperado = (((k - 1) % 3) < 2) ? 4'b0001 : 4'b0000;
         cmp($sformatf("exp2.c%0d", k), 32'(g2), 32'(esperado));
      end

      // Randomized traffic; requests tend to persist so expiries happen
      ciclo(4'b0000, 1'b1);
      r_alea = 4'b0000;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 3) == 0) r_alea = 4'($urandom_range(0, 15));
         ciclo(r_alea, ($urandom_range(0, 79) == 0));
      end

      armado = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
      $finish;
   end

endmodule
